// File: rtl/div_uns_pkg.sv
// div_uns_pkg
// Shared definitions for the iterative unsigned restoring divider:
//   - div_state_e : controller states (IDLE / CALC / DONE)
//   - iter_count  : number of iteration cycles for a given dividend width
//                   and quotient bits per cycle
//   - bpc_legal   : parameter legality check used at elaboration
package div_uns_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // One iteration cycle resolves bpc quotient bits.
    function automatic int iter_count(input int wx, input int bpc);
        return wx / bpc;
    endfunction

    // Only 1, 2 or 4 bits per cycle are supported, and they must tile the
    // dividend exactly so the last iteration lands on bit 0.
    function automatic bit bpc_legal(input int bpc, input int wx);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((wx % bpc) == 0);
    endfunction

endpackage

// File: rtl/div_uns_step.sv
// div_uns_step
// One combinational restoring-division step.
// Ports:
//   rem_i  [widthY:0]   partial remainder entering the step (always < div_i)
//   bit_i               next dividend bit, shifted in at the LSB
//   div_i  [widthY-1:0] divisor
//   rem_o  [widthY:0]   partial remainder leaving the step
//   q_o                 resolved quotient bit
module div_uns_step #(
    parameter int widthY = 16
) (
    input  logic [widthY:0]   rem_i,
    input  logic              bit_i,
    input  logic [widthY-1:0] div_i,
    output logic [widthY:0]   rem_o,
    output logic              q_o
);

    logic [widthY+1:0] shifted;
    logic [widthY:0]   diff;
    logic              ge;

    always_comb begin
        shifted = {rem_i, bit_i};
        ge      = (shifted >= {2'b00, div_i});
        // When ge holds the true difference is below the divisor, so the
        // low widthY+1 bits of the subtraction are exact.
        diff    = shifted[widthY:0] - {1'b0, div_i};
        rem_o   = ge ? diff : shifted[widthY:0];
        q_o     = ge;
    end

endmodule

// File: rtl/div_uns_seq.sv
// div_uns_seq
// Iterative unsigned restoring divider: Q = X / Y, R = X mod Y, resolving
// bitsPerCycle quotient bits per clock. Valid/ready on both sides.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   in_valid_i   operands valid          in_ready_o   operands accepted (IDLE)
//   X [widthX]   dividend                Y [widthY]   divisor
//   out_valid_o  result valid (DONE)     out_ready_i  consumer takes result
//   Q [widthX]   quotient                R [widthY]   remainder
//   dz_o         divide-by-zero flag, present only when DIVUNS_DZ_FLAG_EN
//                is defined
// Divide by zero returns Q = all ones, R = X (truncated/zero-extended) one
// cycle after accept.
module div_uns_seq
    import div_uns_pkg::*;
#(
    parameter int widthX       = 16,
    parameter int widthY       = 16,
    parameter int bitsPerCycle = 1
) (
`ifdef DIVUNS_DZ_FLAG_EN
    output logic              dz_o,
`endif
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [widthX-1:0] X,
    input  logic [widthY-1:0] Y,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [widthX-1:0] Q,
    output logic [widthY-1:0] R
);

    localparam int ITER = iter_count(widthX, bitsPerCycle);
    localparam int CW   = $clog2(ITER + 1);

    generate
        if (!bpc_legal(bitsPerCycle, widthX)) begin : g_bad_bpc
            $error("div_uns_seq: bitsPerCycle must be 1, 2 or 4 and divide widthX");
        end
    endgenerate

    div_state_e        state_q, state_d;
    logic [widthX-1:0] quot_q, quot_d;    // dividend in, quotient shifts out
    logic [widthY:0]   rem_q, rem_d;      // partial remainder
    logic [widthY-1:0] div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Chain of bitsPerCycle restoring steps fed from the registered state.
    logic [widthY:0]       rem_chain [bitsPerCycle+1];
    logic [bitsPerCycle-1:0] q_bits;
    logic [widthX-1:0]     quot_step;

    assign rem_chain[0] = rem_q;

    generate
        for (genvar gi = 0; gi < bitsPerCycle; gi++) begin : g_step
            div_uns_step #(.widthY(widthY)) u_step (
                .rem_i (rem_chain[gi]),
                .bit_i (quot_q[widthX-1-gi]),
                .div_i (div_q),
                .rem_o (rem_chain[gi+1]),
                .q_o   (q_bits[bitsPerCycle-1-gi])
            );
        end
    endgenerate

    // Consumed dividend bits leave at the top, new quotient bits enter below.
    assign quot_step = (quot_q << bitsPerCycle) | widthX'(q_bits);

    always_comb begin
        state_d     = state_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    div_d = Y;
                    if (Y == '0) begin
                        quot_d  = '1;
                        rem_d   = {1'b0, widthY'(X)};
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        quot_d  = X;
                        rem_d   = '0;
                        cnt_d   = CW'(ITER);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quot_d = quot_step;
                rem_d  = rem_chain[bitsPerCycle];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Q = quot_q;
    assign R = rem_q[widthY-1:0];

`ifdef DIVUNS_DZ_FLAG_EN
    logic dz_q, dz_d;

    // Captured at accept, held through backpressure, dropped on handshake.
    always_comb begin
        dz_d = dz_q;
        if ((state_q == IDLE) && in_valid_i) begin
            dz_d = (Y == '0);
        end else if ((state_q == DONE) && out_ready_i) begin
            dz_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign dz_o = dz_q;
`endif

endmodule
